// File: rtl/jelly3_jfive_shift_issue.sv
// jelly3_jfive_shift_issue
// Issue stage for the jfive pipelined shifter. Decodes RV32I shift words
// (SLL/SRL/SRA/SLLI/SRLI/SRAI), reads operands from a local 32x32 register
// file, tracks in-flight destinations in a fixed-latency scoreboard and
// absorbs the shifter writeback into the same register file.
// Optional feature macro: JELLY3_JFIVE_SHIFT_ISSUE_BYPASS_EN
//   defined   : writeback value is forwarded to a same-cycle operand read,
//               so the hazard window is one stage shorter.
//   undefined : register file read returns the pre-write value.

module jelly3_jfive_shift_issue #(
   parameter int  XLEN       = 32,
   parameter int  SHAMT_BITS = $clog2(XLEN),
   parameter int  LATENCY    = 2,
   parameter type rval_t     = logic [XLEN-1:0],
   parameter type shamt_t    = logic [SHAMT_BITS-1:0],
   parameter type ridx_t     = logic [5:0]
) (
   input  logic        reset,
   input  logic        clk,
   input  logic        cke,
   input  logic [31:0] s_instr,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        m_arithmetic,
   output logic        m_left,
   output logic        m_imm_en,
   output rval_t       m_rs1_val,
   output shamt_t      m_rs2_val,
   output shamt_t      m_shamt,
   output ridx_t       m_rd_idx,
   output logic        m_illegal,
   input  ridx_t       wb_rd_idx,
   input  rval_t       wb_rd_val
);

`ifdef JELLY3_JFIVE_SHIFT_ISSUE_BYPASS_EN
   localparam int HZ_DEPTH = LATENCY;
`else
   localparam int HZ_DEPTH = LATENCY + 1;
`endif

   // decode fields
   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic [4:0] w_rd;
   logic       w_op_r;
   logic       w_op_i;
   logic       w_legal;
   logic       w_hazard;
   logic       w_accept;
   logic       w_unused;

   assign w_opcode = s_instr[6:0];
   assign w_rd     = s_instr[11:7];
   assign w_funct3 = s_instr[14:12];
   assign w_rs1    = s_instr[19:15];
   assign w_rs2    = s_instr[24:20];
   assign w_funct7 = s_instr[31:25];
   assign w_op_r   = (w_opcode == 7'b0110011);
   assign w_op_i   = (w_opcode == 7'b0010011);
   assign w_legal  = (w_op_r | w_op_i)
                   & (((w_funct3 == 3'b001) & (w_funct7 == 7'b0000000))
                    | ((w_funct3 == 3'b101) & ((w_funct7 == 7'b0000000) | (w_funct7 == 7'b0100000))));
   assign w_unused = wb_rd_idx[5];

   // state
   rval_t      r_rf [0:31];
   logic [4:0] r_pend [0:LATENCY];
   logic       r_arith;
   logic       r_left;
   logic       r_imm;
   rval_t      r_rs1_val;
   shamt_t     r_rs2_val;
   shamt_t     r_shamt;
   ridx_t      r_rd_idx;
   logic       r_illegal;

   rval_t      w_rs1_val;
   shamt_t     w_rs2_val;

   // RAW hazard: a legal op's nonzero source matches a destination still in flight
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < HZ_DEPTH; i++) begin
         if ((w_rs1 != 5'd0) && (r_pend[i] == w_rs1)) w_hazard = 1'b1;
         if (w_op_r && (w_rs2 != 5'd0) && (r_pend[i] == w_rs2)) w_hazard = 1'b1;
      end
      if (!w_legal) w_hazard = 1'b0;
   end

   assign s_ready  = cke & ~reset & ~w_hazard;
   assign w_accept = s_valid & s_ready;

   // operand read, optionally forwarding a same-cycle writeback
   always_comb begin
      w_rs1_val = r_rf[w_rs1];
      w_rs2_val = r_rf[w_rs2][SHAMT_BITS-1:0];
`ifdef JELLY3_JFIVE_SHIFT_ISSUE_BYPASS_EN
      if (cke && (w_rs1 != 5'd0) && (wb_rd_idx[4:0] == w_rs1)) w_rs1_val = wb_rd_val;
      if (cke && (w_rs2 != 5'd0) && (wb_rd_idx[4:0] == w_rs2)) w_rs2_val = wb_rd_val[SHAMT_BITS-1:0];
`endif
   end

   // register file: writeback lands every enabled cycle, x0 stays zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else if (cke && (wb_rd_idx[4:0] != 5'd0)) begin
         r_rf[wb_rd_idx[4:0]] <= wb_rd_val;
      end
   end

   // scoreboard: destination of each issued op marches one stage per cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= LATENCY; i++) r_pend[i] <= 5'd0;
      end else if (cke) begin
         r_pend[0] <= (w_accept && w_legal) ? w_rd : 5'd0;
         for (int i = 1; i <= LATENCY; i++) r_pend[i] <= r_pend[i-1];
      end
   end

   // shifter operand outputs: loaded on a legal accept, otherwise a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_arith   <= 1'b0;
         r_left    <= 1'b0;
         r_imm     <= 1'b0;
         r_rs1_val <= '0;
         r_rs2_val <= '0;
         r_shamt   <= '0;
         r_rd_idx  <= '0;
         r_illegal <= 1'b0;
      end else if (cke) begin
         r_rd_idx  <= '0;
         r_illegal <= 1'b0;
         if (w_accept) begin
            if (w_legal) begin
               r_arith   <= w_funct7[5];
               r_left    <= (w_funct3 == 3'b001);
               r_imm     <= w_op_i;
               r_rs1_val <= w_rs1_val;
               r_rs2_val <= w_rs2_val;
               r_shamt   <= s_instr[20 +: SHAMT_BITS];
               r_rd_idx  <= {1'b0, w_rd};
            end else begin
               r_illegal <= 1'b1;
            end
         end
      end
   end

   assign m_arithmetic = r_arith;
   assign m_left       = r_left;
   assign m_imm_en     = r_imm;
   assign m_rs1_val    = r_rs1_val;
   assign m_rs2_val    = r_rs2_val;
   assign m_shamt      = r_shamt;
   assign m_rd_idx     = r_rd_idx;
   assign m_illegal    = r_illegal;

endmodule

// File: tb/tb_jelly3_jfive_shift_issue.sv
// Testbench for jelly3_jfive_shift_issue. Acts as the shifter (LAT-cycle
// pipe fed from the DUT operand outputs, returning results on wb_*) and
// keeps an architectural model: register values updated at issue time and
// a per-register "earliest issue edge" for dependent instructions.
// Honours JELLY3_JFIVE_SHIFT_ISSUE_BYPASS_EN for the expected issue spacing.

module tb_jelly3_jfive_shift_issue;
   localparam int LAT = 2;
`ifdef JELLY3_JFIVE_SHIFT_ISSUE_BYPASS_EN
   localparam int GAP = LAT + 1;
`else
   localparam int GAP = LAT + 2;
`endif

   logic        reset, clk, cke, s_valid, s_ready;
   logic        m_arithmetic, m_left, m_imm_en, m_illegal;
   logic [31:0] s_instr, m_rs1_val, wb_rd_val;
   logic [4:0]  m_rs2_val, m_shamt;
   logic [5:0]  m_rd_idx, wb_rd_idx;

   int errors = 0;
   int checks = 0;

   logic [31:0] arch [32];
   int          ready_at [32];
   int          ecyc;
   logic [5:0]  p_idx [LAT];
   logic [31:0] p_val [LAT];
   logic        pre_en;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;

   logic        exp_arith, exp_left, exp_imm, exp_ill, exp_rs2_known;
   logic [4:0]  exp_shamt, exp_rs2;
   logic [5:0]  exp_rd;
   logic [31:0] exp_rs1;

   jelly3_jfive_shift_issue #(.XLEN(32), .LATENCY(LAT)) dut (
      .reset(reset), .clk(clk), .cke(cke),
      .s_instr(s_instr), .s_valid(s_valid), .s_ready(s_ready),
      .m_arithmetic(m_arithmetic), .m_left(m_left), .m_imm_en(m_imm_en),
      .m_rs1_val(m_rs1_val), .m_rs2_val(m_rs2_val), .m_shamt(m_shamt),
      .m_rd_idx(m_rd_idx), .m_illegal(m_illegal),
      .wb_rd_idx(wb_rd_idx), .wb_rd_val(wb_rd_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] b,
                                       input logic [4:0] a, input logic [2:0] f3,
                                       input logic [4:0] d, input logic imm);
      return {f7, b, a, f3, d, imm ? 7'b0010011 : 7'b0110011};
   endfunction

   function automatic logic is_shift(input logic [31:0] w);
      if (w[6:0] != 7'h33 && w[6:0] != 7'h13) return 1'b0;
      case (w[14:12])
         3'b001:  return w[31:25] == 7'h00;
         3'b101:  return w[31:25] == 7'h00 || w[31:25] == 7'h20;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] shf(input logic l, input logic ar,
                                       input logic [31:0] v, input logic [4:0] s);
      if (l) return v << s;
      if (ar) return 32'($signed(v) >>> s);
      return v >> s;
   endfunction

   function automatic logic busy(input logic [4:0] r);
      return (r != 5'd0) && (ready_at[r] > ecyc + 1);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin arch[i] = 32'h0; ready_at[i] = 0; end
      exp_arith = 0; exp_left = 0; exp_imm = 0; exp_ill = 0; exp_rs2_known = 1;
      exp_shamt = 0; exp_rs2 = 0; exp_rd = 0; exp_rs1 = 0;
   endtask

   // one clock: drive, check s_ready, update model, clock, check outputs
   task automatic step(input logic v, input logic [31:0] ins, input logic ce, output logic rdy);
      logic        exp_rdy, acc, lg, imm;
      logic [4:0]  rs1, rs2, rd, amt;
      logic [5:0]  cap_rd;
      logic [31:0] cap_res, res;
      s_valid = v; s_instr = ins; cke = ce;
      if (pre_en) begin wb_rd_idx = pre_idx; wb_rd_val = pre_val; end
      else begin wb_rd_idx = p_idx[LAT-1]; wb_rd_val = p_val[LAT-1]; end
      #1;
      lg  = is_shift(ins);
      imm = (ins[6:0] == 7'h13);
      rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
      exp_rdy = ce && !reset && !(lg && (busy(rs1) || (!imm && busy(rs2))));
      checks++;
      if (s_ready !== exp_rdy) begin
         errors++; $display("FAIL s_ready: got %b expected %b (ins %h t=%0t)", s_ready, exp_rdy, ins, $time);
      end
      rdy = s_ready;
      acc = v && exp_rdy;
      cap_rd  = m_rd_idx;
      cap_res = shf(m_left, m_arithmetic, m_rs1_val, m_imm_en ? m_shamt : m_rs2_val);
      if (ce && !reset) begin
         exp_rd = 0; exp_ill = 0;
         if (acc && lg) begin
            amt = imm ? rs2 : arch[rs2][4:0];
            exp_arith = (ins[31:25] == 7'h20);
            exp_left  = (ins[14:12] == 3'b001);
            exp_imm   = imm;
            exp_shamt = rs2;
            exp_rs1   = arch[rs1];
            exp_rs2   = arch[rs2][4:0];
            exp_rs2_known = !imm;
            exp_rd    = {1'b0, rd};
            res = shf(exp_left, exp_arith, arch[rs1], amt);
            if (rd != 5'd0) begin arch[rd] = res; ready_at[rd] = ecyc + 1 + GAP; end
         end else if (acc) begin
            exp_ill = 1;
         end
         if (pre_en && pre_idx[4:0] != 5'd0) arch[pre_idx[4:0]] = pre_val;
         ecyc++;
      end
      @(posedge clk);
      if (ce) begin
         for (int i = LAT-1; i > 0; i--) begin p_idx[i] = p_idx[i-1]; p_val[i] = p_val[i-1]; end
         p_idx[0] = cap_rd; p_val[0] = cap_res;
      end
      #1;
      checks++;
      if ({m_arithmetic, m_left, m_imm_en, m_shamt, m_rd_idx, m_illegal} !==
          {exp_arith, exp_left, exp_imm, exp_shamt, exp_rd, exp_ill}) begin
         errors++;
         $display("FAIL ctrl: got ar%b l%b i%b sh%0d rd%0d il%b expected ar%b l%b i%b sh%0d rd%0d il%b t=%0t",
                  m_arithmetic, m_left, m_imm_en, m_shamt, m_rd_idx, m_illegal,
                  exp_arith, exp_left, exp_imm, exp_shamt, exp_rd, exp_ill, $time);
      end
      checks++;
      if (m_rs1_val !== exp_rs1) begin
         errors++; $display("FAIL rs1_val: got %h expected %h t=%0t", m_rs1_val, exp_rs1, $time);
      end
      if (exp_rs2_known) begin
         checks++;
         if (m_rs2_val !== exp_rs2) begin
            errors++; $display("FAIL rs2_val: got %h expected %h t=%0t", m_rs2_val, exp_rs2, $time);
         end
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] val);
      logic r;
      repeat (LAT + 1) step(1'b0, 32'h0, 1'b1, r);
      pre_en = 1; pre_idx = idx; pre_val = val;
      step(1'b0, 32'h0, 1'b1, r);
      pre_en = 0;
   endtask

   task automatic do_reset(input int n);
      logic r;
      reset = 1; s_valid = 0;
      #1;
      checks++;
      if ({m_arithmetic, m_left, m_imm_en, m_shamt, m_rd_idx, m_illegal, m_rs1_val, m_rs2_val} !== '0) begin
         errors++; $display("FAIL reset_outputs: got rd%0d rs1 %h il%b expected all zero", m_rd_idx, m_rs1_val, m_illegal);
      end
      checks++;
      if (s_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b expected 0", s_ready);
      end
      clear_model();
      repeat (n) step(1'b0, 32'h0, 1'b1, r);
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset(3);
   endtask

   task automatic test_srai();
      logic r;
      preload(6'd1, 32'h8000_00F0);
      step(1'b1, enc(7'h20, 5'd4, 5'd1, 3'b101, 5'd2, 1'b1), 1'b1, r);
      checks++;
      if (r !== 1'b1 || {m_arithmetic, m_left, m_imm_en, m_shamt, m_rs1_val, m_rd_idx} !==
                        {1'b1, 1'b0, 1'b1, 5'd4, 32'h8000_00F0, 6'd2}) begin
         errors++; $display("FAIL srai: got rdy%b ar%b l%b i%b sh%0d rs1 %h rd%0d expected 1 1 0 1 4 800000f0 2",
                            r, m_arithmetic, m_left, m_imm_en, m_shamt, m_rs1_val, m_rd_idx);
      end
   endtask

   task automatic test_dependent();
      int   stalls = 0;
      logic r = 0;
      for (int i = 0; i < 10 && !r; i++) begin
         step(1'b1, enc(7'h00, 5'd4, 5'd2, 3'b001, 5'd3, 1'b0), 1'b1, r);
         if (!r) stalls++;
      end
      checks++;
      if (!r) begin errors++; $display("FAIL dep_timeout: got no accept expected accept within 10 cycles"); end
      checks++;
      if (stalls != GAP - 1) begin errors++; $display("FAIL dep_stalls: got %0d expected %0d", stalls, GAP - 1); end
      checks++;
      if (m_rs1_val !== 32'hF800_000F || m_left !== 1'b1) begin
         errors++; $display("FAIL dep_operand: got %h l%b expected f800000f l1", m_rs1_val, m_left);
      end
   endtask

   task automatic test_back_to_back();
      logic r;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, enc(7'h00, 5'(i + 1), 5'd1, 3'b001, 5'(5 + i), 1'b1), 1'b1, r);
         checks++;
         if (r !== 1'b1 || m_rd_idx !== 6'(5 + i)) begin
            errors++; $display("FAIL b2b_%0d: got rdy%b rd%0d expected rdy1 rd%0d", i, r, m_rd_idx, 5 + i);
         end
      end
   endtask

   task automatic test_illegal();
      logic r;
      step(1'b1, enc(7'h00, 5'd7, 5'd8, 3'b000, 5'd1, 1'b0), 1'b1, r);
      checks++;
      if (r !== 1'b1 || m_illegal !== 1'b1 || m_rd_idx !== 6'd0) begin
         errors++; $display("FAIL illegal_nostall: got rdy%b il%b rd%0d expected 1 1 0", r, m_illegal, m_rd_idx);
      end
      step(1'b1, 32'h0000_0033, 1'b1, r);
      checks++;
      if (r !== 1'b1 || m_illegal !== 1'b1 || m_rd_idx !== 6'd0) begin
         errors++; $display("FAIL illegal_add: got rdy%b il%b rd%0d expected 1 1 0", r, m_illegal, m_rd_idx);
      end
      step(1'b0, 32'h0, 1'b1, r);
      checks++;
      if (m_illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %b expected 0", m_illegal); end
   endtask

   task automatic test_x0();
      logic r;
      preload(6'd0, 32'hDEAD_BEEF);
      step(1'b1, enc(7'h00, 5'd0, 5'd0, 3'b101, 5'd9, 1'b0), 1'b1, r);
      checks++;
      if (r !== 1'b1 || m_rs1_val !== 32'h0 || m_rs2_val !== 5'd0 || m_rd_idx !== 6'd9) begin
         errors++; $display("FAIL x0_read: got rdy%b rs1 %h rs2 %h rd%0d expected 1 0 0 9", r, m_rs1_val, m_rs2_val, m_rd_idx);
      end
   endtask

   task automatic test_cke();
      logic r;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, enc(7'h00, 5'd1, 5'd1, 3'b001, 5'd15, 1'b1), 1'b0, r);
         checks++;
         if (r !== 1'b0) begin errors++; $display("FAIL cke_ready: got %b expected 0", r); end
      end
      step(1'b1, enc(7'h00, 5'd1, 5'd1, 3'b001, 5'd15, 1'b1), 1'b1, r);
      checks++;
      if (r !== 1'b1 || m_rd_idx !== 6'd15) begin
         errors++; $display("FAIL cke_resume: got rdy%b rd%0d expected 1 15", r, m_rd_idx);
      end
   endtask

   task automatic test_reset_mid();
      logic r;
      step(1'b1, enc(7'h00, 5'd1, 5'd1, 3'b001, 5'd10, 1'b1), 1'b1, r);
      step(1'b1, enc(7'h00, 5'd2, 5'd1, 3'b001, 5'd11, 1'b1), 1'b1, r);
      do_reset(LAT + 2);
      step(1'b1, enc(7'h00, 5'd3, 5'd10, 3'b001, 5'd12, 1'b1), 1'b1, r);
      checks++;
      if (r !== 1'b1 || m_rs1_val !== 32'h0 || m_rd_idx !== 6'd12) begin
         errors++; $display("FAIL reset_mid: got rdy%b rs1 %h rd%0d expected 1 0 12", r, m_rs1_val, m_rd_idx);
      end
   endtask

   task automatic test_random();
      logic        r, ce, v;
      logic [31:0] w;
      logic [4:0]  a, b, d;
      for (int i = 1; i < 8; i++) preload(6'(i), $urandom);
      for (int n = 0; n < 400; n++) begin
         a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0: w = enc(7'h00, b, a, 3'b001, d, 1'b0);
            1: w = enc(7'h00, b, a, 3'b101, d, 1'b0);
            2: w = enc(7'h20, b, a, 3'b101, d, 1'b0);
            3: w = enc(7'h00, 5'($urandom), a, 3'b001, d, 1'b1);
            4: w = enc(7'h00, 5'($urandom), a, 3'b101, d, 1'b1);
            5: w = enc(7'h20, 5'($urandom), a, 3'b101, d, 1'b1);
            6: w = enc(7'h20, b, a, 3'b001, d, 1'b0);
            7: w = $urandom;
            default: w = enc(7'h20, b, a, 3'b101, d, 1'b0);
         endcase
         ce = ($urandom_range(0, 9) != 0);
         v  = ($urandom_range(0, 3) != 0);
         step(v, w, ce, r);
      end
   endtask

   initial begin
      reset = 1; cke = 0; s_valid = 0; s_instr = 0; wb_rd_idx = 0; wb_rd_val = 0;
      pre_en = 0; pre_idx = 0; pre_val = 0; ecyc = 0;
      for (int i = 0; i < LAT; i++) begin p_idx[i] = 0; p_val[i] = 0; end
      clear_model();
      @(posedge clk);
      #1;
      test_reset();
      test_srai();
      test_dependent();
      test_back_to_back();
      test_illegal();
      test_x0();
      test_cke();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jelly3_jfive_shift_issue.md
# jelly3_jfive_shift_issue

Issue stage feeding the jfive pipelined shifter: accepts RV32I instruction words over a valid/ready handshake, decodes SLL/SRL/SRA/SLLI/SRLI/SRAI, reads operands from an internal 32×32 register file, and drives the shifter's operand inputs. It also absorbs the shifter's writeback (`rd_idx`/`rd_val`) into that register file. A fixed-latency scoreboard stalls on read-after-write hazards, so the block closes the loop around the shifter.

## Interface
Parameters:
- XLEN, 32, data width; SHAMT_BITS = $clog2(XLEN).
- LATENCY, 2, shifter latency in cycles from operand inputs to `rd_val`.
- rval_t, logic [XLEN-1:0], register value type.
- shamt_t, logic [SHAMT_BITS-1:0], shift amount type.
- ridx_t, logic [5:0], register index type (bit 5 always driven 0).

Ports (one clock; reset is asynchronous and active-high):
- reset  in  1  async active-high reset
- clk  in  1  clock
- cke  in  1  clock enable; 0 freezes all state, `s_ready`=0
- s_instr  in  32  instruction word
- s_valid  in  1  instruction valid
- s_ready  out  1  instruction accepted when `s_valid & s_ready`
- m_arithmetic, m_left, m_imm_en  out  1 each  shifter controls
- m_rs1_val  out  XLEN  shift source
- m_rs2_val  out  SHAMT_BITS  rs2[SHAMT_BITS-1:0]
- m_shamt  out  SHAMT_BITS  immediate shamt (instr[24:20])
- m_rd_idx  out  6  destination; 0 = bubble / no write
- m_illegal  out  1  one-cycle pulse: accepted word was not a shift
- wb_rd_idx  in  6  shifter result index
- wb_rd_val  in  XLEN  shifter result value

## Operation
- Decode: opcode 0110011 + funct3 001/funct7 0000000 → SLL; funct3 101/funct7 0000000 → SRL; funct3 101/funct7 0100000 → SRA. Opcode 0010011 applies the same rules to imm[11:5] → SLLI/SRLI/SRAI with `m_imm_en`=1. Every other word is illegal.
- `m_left` = funct3==001; `m_arithmetic` = funct7[5]; `m_imm_en` = opcode==0010011.
- Register file: x0 reads 0 and is never written. A write occurs every cycle where `wb_rd_idx[4:0]`≠0.
- Scoreboard: a PEND shift register, LATENCY+1 deep, holds the rd of each issued op (0 for bubble/illegal) and advances every cke cycle.
- Hazard: a legal instruction's rs1 (and rs2 for R-type) ≠0 matches a PEND stage 0..LATENCY-1 entry.
- `s_ready` = cke & ~hazard. Illegal words are never stalled.
- On accept of a legal op: register the m_* outputs, with rd into `m_rd_idx` and PEND[0].
- On accept of an illegal op: `m_illegal`=1, `m_rd_idx`=0.
- No accept: `m_rd_idx`=0 (bubble); other m_* hold.
- Operand read and wb write in the same cycle to the same register: the read returns `wb_rd_val` (bypass).

## Timing
- Reset values: all m_* = 0, `m_illegal`=0, `s_ready`=0 while reset is asserted, PEND all 0, register file all 0.
- Accept at edge N → m_* valid during cycle N+1. Shifter result on `wb_*` during cycle N+1+LATENCY, written at the end of that cycle.
- A dependent instruction is accepted no earlier than edge N+LATENCY+1, i.e. back-to-back dependent issue spacing = LATENCY+1 cycles (3 at default). With bypass, its operand read coincides with the wb cycle.
- Independent instructions issue every cycle.
- Reset asserted mid-stream: in-flight PEND entries are discarded immediately; writebacks arriving after reset deassertion are still written.
- cke=0: PEND, outputs and register file hold; wb is ignored (the shifter shares cke).

## Configuration
- JELLY3_JFIVE_SHIFT_ISSUE_BYPASS_EN defined: wb→read bypass present, hazard check covers PEND stages 0..LATENCY-1, dependent spacing LATENCY+1.
- JELLY3_JFIVE_SHIFT_ISSUE_BYPASS_EN undefined: no bypass (the register file read returns the pre-write value). The hazard check covers stages 0..LATENCY, so dependent spacing is LATENCY+2. Results are identical; only stall counts differ.

## Test plan
- Reset then preload x1=0x8000_00F0 via wb; issue SRAI x2,x1,4 → cycle+1 drives `m_arithmetic`=1, `m_left`=0, `m_imm_en`=1, `m_shamt`=4, `m_rs1_val`=0x8000_00F0, `m_rd_idx`=2.
- SLL x3,x2,x4 right after SRAI x2 (dependent) → `s_ready` low for 2 cycles (3 without BYPASS_EN). Operand equals the shifter's result 0xF800_000F.
- Four independent SLLI to x5..x8 with `s_valid` held → accepted on 4 consecutive edges, `m_rd_idx` 5,6,7,8.
- Word 0x0000_0033 (ADD) → accepted, `m_illegal` pulses 1 cycle, `m_rd_idx`=0, PEND unaffected.
- Write to x0 via wb with value 0xDEAD_BEEF, then SRL x9,x0,x0 → `m_rs1_val`=0, `m_rs2_val`=0, no stall.
- Assert reset while 2 ops are pending, deassert, then issue dependent op → no stall, m_* start from 0.
